exp_fix2float: RTL

//  Downstream stage of the exponential unit. Takes the unsigned 22.25 fixed-point
//  exp result (47 bits) and converts it to IEEE-754 single precision.

---
 rtl/exp_pkg.sv | 18 +
 rtl/exp_lod47.sv | 19 +
 rtl/exp_fix2float.sv | 112 +++++++++++
 3 files changed

// File: rtl/exp_pkg.sv
// Shared constants and packed float format for the exp fixed-to-float stage.
package exp_pkg;
    localparam int IN_W   = 47;
    localparam int FRAC_W = 25;
    localparam int BIAS   = 127;
    localparam int MANT_W = 23;
    localparam int EXP_W  = 8;
    localparam int P_W    = 6;

    // Exponent of a value whose leading one sits at fixed-point bit 0.
    localparam logic [EXP_W-1:0] EXP_OFF = EXP_W'(BIAS - FRAC_W);

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } float_t;
endpackage

// File: rtl/exp_lod47.sv
// Combinational leading-one detector: index of the highest set bit plus an all-zero flag.
module exp_lod47
    import exp_pkg::*;
(
    input  logic [IN_W-1:0] i_data,
    output logic [P_W-1:0]  o_p,
    output logic            o_zero
);

    // Scan upward so the highest set bit is the last one written.
    always_comb begin
        o_p = P_W'(0);
        for (int i = 0; i < IN_W; i++) begin
            o_p = i_data[i] ? P_W'(i) : o_p;
        end
        o_zero = ~|i_data;
    end

endmodule

// File: rtl/exp_fix2float.sv
// Unsigned 22.25 fixed point to IEEE-754 single, 3-stage valid/ready pipeline.
// Define EXP_F2F_ROUND_EN for round-to-nearest-even; otherwise results truncate.
module exp_fix2float
    import exp_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [31:0]     out_float,
    output logic            out_inexact,
    output logic            out_valid,
    input  logic            out_ready
);

    logic              r_v1;
    logic              r_v2;
    logic              r_v3;
    logic [IN_W-1:0]   r_d1;
    logic [IN_W-2:0]   r_d2;
    logic [P_W-1:0]    r_p2;
    logic              r_z2;
    logic              w_adv1;
    logic              w_adv2;
    logic              w_adv3;
    logic [P_W-1:0]    w_p;
    logic              w_zero;
    logic [P_W-1:0]    w_shamt;
    logic [IN_W-2:0]   w_norm;
    logic [MANT_W-1:0] w_mant_t;
    logic              w_guard;
    logic              w_sticky;
    logic              w_inexact;
    logic [MANT_W:0]   w_mant_r;
    float_t            w_pack;
    float_t            w_float;

    assign w_adv3    = ~r_v3 | out_ready;
    assign w_adv2    = ~r_v2 | w_adv3;
    assign w_adv1    = ~r_v1 | w_adv2;
    assign in_ready  = w_adv1;
    assign out_valid = r_v3;

    exp_lod47 u_lod (
        .i_data (r_d1),
        .o_p    (w_p),
        .o_zero (w_zero)
    );

    // S3: drop the leading one by normalising it just above bit IN_W-2, then split and pack.
    always_comb begin
        w_shamt   = P_W'(IN_W - 1) - r_p2;
        w_norm    = r_d2 << w_shamt;
        w_mant_t  = w_norm[IN_W-2 -: MANT_W];
        w_guard   = w_norm[IN_W-2-MANT_W];
        w_sticky  = |w_norm[IN_W-3-MANT_W:0];
`ifdef EXP_F2F_ROUND_EN
        w_mant_r  = {1'b0, w_mant_t} + {{MANT_W{1'b0}}, w_guard & (w_sticky | w_mant_t[0])};
`else
        w_mant_r  = {1'b0, w_mant_t};
`endif
        w_pack.sign = 1'b0;
        w_pack.exp  = EXP_OFF + EXP_W'(r_p2) + EXP_W'(w_mant_r[MANT_W]);
        w_pack.mant = w_mant_r[MANT_W-1:0];
        if (r_z2) begin
            w_float   = float_t'(32'h0000_0000);
            w_inexact = 1'b0;
        end else begin
            w_float   = w_pack;
            w_inexact = w_guard | w_sticky;
        end
    end

    // Pipeline registers; a stage loads only when its successor can take its contents.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_v3        <= 1'b0;
            r_d1        <= {IN_W{1'b0}};
            r_d2        <= {(IN_W-1){1'b0}};
            r_p2        <= P_W'(0);
            r_z2        <= 1'b0;
            out_float   <= 32'h0000_0000;
            out_inexact <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_d1 <= in_data;
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_d2 <= r_d1[IN_W-2:0];
                    r_p2 <= w_p;
                    r_z2 <= w_zero;
                end
            end
            if (w_adv3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    out_float   <= w_float;
                    out_inexact <= w_inexact;
                end
            end
        end
    end

endmodule
